// File: rtl/alu_param_seq_if.sv
// Request/result bundle between the operand register file, the ALU and writeback.
// The master drives requests and the slave (the ALU) returns results and flags.
interface alu_param_seq_if #(parameter int WIDTH = 16);
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ALU_FUN;
  logic             OUT_VALID;
  logic [WIDTH-1:0] ALU_OUT;
  logic             Carry_Flag;
  logic             Arith_Flag;
  logic             Logic_Flag;
  logic             CMP_Flag;
  logic             Shift_Flag;
  logic             Div_Zero;

  modport master (
    output IN_VALID, A, B, ALU_FUN,
    input  IN_READY, OUT_VALID, ALU_OUT, Carry_Flag, Arith_Flag,
           Logic_Flag, CMP_Flag, Shift_Flag, Div_Zero
  );

  modport slave (
    input  IN_VALID, A, B, ALU_FUN,
    output IN_READY, OUT_VALID, ALU_OUT, Carry_Flag, Arith_Flag,
           Logic_Flag, CMP_Flag, Shift_Flag, Div_Zero
  );
endinterface

// File: rtl/alu_param_seq.sv
// Parametrised ALU with valid/ready input. Most ops finish in one cycle; DIV/MOD
// with a nonzero divisor use a WIDTH-step restoring divider while IN_READY is low.
module alu_param_seq #(
  parameter int WIDTH = 16
) (
  input  logic CLK,
  input  logic RST,
  alu_param_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, DIV} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] out_q, q_q, d_q;
  logic [WIDTH:0]   r_q;
  logic [CW-1:0]    cnt_q;
  logic             mod_q;
  logic             ovld_q, carry_q, arith_q, logic_q, cmp_q, shift_q, dz_q;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res;
  logic               c, dz;
  logic [1:0]         cat;  // 0 arith, 1 logic, 2 compare, 3 shift
  logic               accept, is_div, go_div, last;
  logic [WIDTH:0]     r_sh, r_d;
  logic [WIDTH-1:0]   q_d;
  logic               ge;

  assign accept = bus.IN_VALID && (state_q == IDLE);
  assign is_div = (bus.ALU_FUN == 4'h3) || (bus.ALU_FUN == 4'hF);
  assign go_div = accept && is_div && (bus.B != '0);

  always_comb begin
    sum  = {1'b0, bus.A} + {1'b0, bus.B};
    prod = {{WIDTH{1'b0}}, bus.A} * {{WIDTH{1'b0}}, bus.B};
    res  = '0;
    c    = 1'b0;
    dz   = 1'b0;
    cat  = 2'd0;
    case (bus.ALU_FUN)
      4'h0: begin res = sum[WIDTH-1:0]; c = sum[WIDTH]; end
      4'h1: begin res = bus.A - bus.B; c = bus.A < bus.B; end
      4'h2: begin res = prod[WIDTH-1:0]; c = |prod[2*WIDTH-1:WIDTH]; end
      4'h3, 4'hF: dz = (bus.B == '0);
      4'h4: begin res = bus.A & bus.B;    cat = 2'd1; end
      4'h5: begin res = bus.A | bus.B;    cat = 2'd1; end
      4'h6: begin res = ~(bus.A & bus.B); cat = 2'd1; end
      4'h7: begin res = ~(bus.A | bus.B); cat = 2'd1; end
      4'h8: begin res = bus.A ^ bus.B;    cat = 2'd1; end
      4'h9: begin res = ~(bus.A ^ bus.B); cat = 2'd1; end
      4'hA: begin res = (bus.A == bus.B) ? WIDTH'(1) : '0; cat = 2'd2; end
      4'hB: begin res = (bus.A >  bus.B) ? WIDTH'(2) : '0; cat = 2'd2; end
      4'hC: begin res = (bus.A <  bus.B) ? WIDTH'(3) : '0; cat = 2'd2; end
      4'hD: begin res = bus.A >> 1; cat = 2'd3; end
      default: begin res = bus.A << 1; cat = 2'd3; end
    endcase
  end

  // One restoring step; R < D holds before the shift, so WIDTH+1 bits suffice.
  always_comb begin
    r_sh = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    ge   = r_sh >= {1'b0, d_q};
    r_d  = ge ? (r_sh - {1'b0, d_q}) : r_sh;
    q_d  = {q_q[WIDTH-2:0], ge};
    last = (cnt_q == CW'(WIDTH - 1));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      out_q   <= '0;
      q_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      mod_q   <= 1'b0;
      ovld_q  <= 1'b0;
      carry_q <= 1'b0;
      arith_q <= 1'b0;
      logic_q <= 1'b0;
      cmp_q   <= 1'b0;
      shift_q <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      ovld_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (go_div) begin
            state_q <= DIV;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= bus.A;
            d_q     <= bus.B;
            mod_q   <= bus.ALU_FUN[2];
          end else if (accept) begin
            out_q   <= res;
            carry_q <= c;
            arith_q <= (cat == 2'd0);
            logic_q <= (cat == 2'd1);
            cmp_q   <= (cat == 2'd2);
            shift_q <= (cat == 2'd3);
            dz_q    <= dz;
            ovld_q  <= 1'b1;
          end
        end
        default: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + CW'(1);
          if (last) begin
            state_q <= IDLE;
            out_q   <= mod_q ? r_d[WIDTH-1:0] : q_d;
            carry_q <= 1'b0;
            arith_q <= 1'b1;
            logic_q <= 1'b0;
            cmp_q   <= 1'b0;
            shift_q <= 1'b0;
            dz_q    <= 1'b0;
            ovld_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.IN_READY   = (state_q == IDLE);
  assign bus.OUT_VALID  = ovld_q;
  assign bus.ALU_OUT    = out_q;
  assign bus.Carry_Flag = carry_q;
  assign bus.Arith_Flag = arith_q;
  assign bus.Logic_Flag = logic_q;
  assign bus.CMP_Flag   = cmp_q;
  assign bus.Shift_Flag = shift_q;
  assign bus.Div_Zero   = dz_q;
endmodule

// File: tb/tb_alu_param_seq.sv
// Scoreboard bench for alu_param_seq: directed cases plus random ops against an
// arithmetic reference model; a negedge monitor checks results, timing and IN_READY.
module tb_alu_param_seq;
  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] res;
    logic c, ar, lg, cm, sh, dz;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   cyc = 0;
  int   busy_end = 0;
  int   nchk = 0;
  int   nerr = 0;
  exp_t expq[$];
  int   tq[$];

  alu_param_seq_if #(.WIDTH(W)) bus ();
  alu_param_seq #(.WIDTH(W)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, b);
    exp_t e;
    longint unsigned ua, ub, p;
    ua = a; ub = b;
    e = '0;
    if (op <= 4'h3 || op == 4'hF) e.ar = 1'b1;
    else if (op <= 4'h9)          e.lg = 1'b1;
    else if (op <= 4'hC)          e.cm = 1'b1;
    else                          e.sh = 1'b1;
    case (op)
      4'h0: begin e.res = W'(ua + ub); e.c = (ua + ub) >= (64'd1 << W); end
      4'h1: begin e.res = W'(ua - ub); e.c = ua < ub; end
      4'h2: begin p = ua * ub; e.res = W'(p); e.c = p >= (64'd1 << W); end
      4'h3: if (ub == 0) e.dz = 1'b1; else e.res = W'(ua / ub);
      4'hF: if (ub == 0) e.dz = 1'b1; else e.res = W'(ua % ub);
      4'h4: e.res = a & b;
      4'h5: e.res = a | b;
      4'h6: e.res = ~(a & b);
      4'h7: e.res = ~(a | b);
      4'h8: e.res = a ^ b;
      4'h9: e.res = ~(a ^ b);
      4'hA: e.res = (ua == ub) ? W'(1) : W'(0);
      4'hB: e.res = (ua >  ub) ? W'(2) : W'(0);
      4'hC: e.res = (ua <  ub) ? W'(3) : W'(0);
      4'hD: e.res = W'(ua / 2);
      default: e.res = W'(ua * 2);
    endcase
    return e;
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit push);
    int n = 0;
    bit slow;
    while (bus.IN_READY !== 1'b1) begin
      @(posedge CLK); #1;
      n++;
      if (n > 100) begin
        nchk++; nerr++;
        $display("FAIL ready_timeout: IN_READY=%b, required 1 within 100 cycles", bus.IN_READY);
        return;
      end
    end
    bus.IN_VALID = 1'b1; bus.A = a; bus.B = b; bus.ALU_FUN = op;
    @(posedge CLK); #1;
    bus.IN_VALID = 1'b0;
    slow = (op == 4'h3 || op == 4'hF) && (b != 0);
    if (slow) busy_end = cyc + W;
    if (push) begin
      expq.push_back(model(op, a, b));
      tq.push_back(slow ? cyc + W : cyc);
    end
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
      nchk++;
      if (bus.IN_READY !== (cyc >= busy_end)) begin
        nerr++;
        $display("FAIL in_ready @%0d: got %b, required %b", cyc, bus.IN_READY, cyc >= busy_end);
      end
      if (bus.OUT_VALID === 1'b1) begin
        exp_t e, g;
        int t;
        nchk++;
        if (expq.size() == 0) begin
          nerr++;
          $display("FAIL unexpected_out_valid @%0d: ALU_OUT=%h with nothing outstanding", cyc, bus.ALU_OUT);
        end else begin
          e = expq.pop_front();
          t = tq.pop_front();
          g = '{bus.ALU_OUT, bus.Carry_Flag, bus.Arith_Flag, bus.Logic_Flag,
                bus.CMP_Flag, bus.Shift_Flag, bus.Div_Zero};
          if (g !== e) begin
            nerr++;
            $display("FAIL result @%0d: got out=%h c%b a%b l%b m%b s%b z%b, required out=%h c%b a%b l%b m%b s%b z%b",
                     cyc, g.res, g.c, g.ar, g.lg, g.cm, g.sh, g.dz, e.res, e.c, e.ar, e.lg, e.cm, e.sh, e.dz);
          end
          nchk++;
          if (t != cyc) begin
            nerr++;
            $display("FAIL latency: OUT_VALID at cycle %0d, required cycle %0d", cyc, t);
          end
        end
      end
    end
  end

  task automatic check_idle_zero(input string name);
    nchk++;
    if ({bus.ALU_OUT, bus.Carry_Flag, bus.Arith_Flag, bus.Logic_Flag, bus.CMP_Flag,
         bus.Shift_Flag, bus.Div_Zero, bus.OUT_VALID, bus.IN_READY} !== {{W{1'b0}}, 8'b0000_0001}) begin
      nerr++;
      $display("FAIL %s: out=%h flags=%b%b%b%b%b%b vld=%b rdy=%b, required all zero and rdy=1", name,
               bus.ALU_OUT, bus.Carry_Flag, bus.Arith_Flag, bus.Logic_Flag, bus.CMP_Flag,
               bus.Shift_Flag, bus.Div_Zero, bus.OUT_VALID, bus.IN_READY);
    end
  endtask

  initial begin
    bus.IN_VALID = 1'b0; bus.A = '0; bus.B = '0; bus.ALU_FUN = '0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    check_idle_zero("reset_state");

    issue(4'h0, 16'hFFFF, 16'h0001, 1);
    issue(4'h3, 16'd100, 16'd7, 1);
    // Requests while busy must be dropped, not queued.
    bus.IN_VALID = 1'b1; bus.ALU_FUN = 4'h0; bus.A = 16'h1234; bus.B = 16'h1;
    repeat (3) @(posedge CLK);
    #1 bus.IN_VALID = 1'b0;
    issue(4'hF, 16'd100, 16'd7, 1);
    issue(4'h3, 16'd14, 16'd0, 1);
    issue(4'h2, 16'h0100, 16'h0100, 1);
    issue(4'h2, 16'd4, 16'd3, 1);
    issue(4'h1, 16'd15, 16'd4, 1);
    issue(4'h8, 16'hAAAA, 16'h5555, 1);
    issue(4'hB, 16'hF, 16'hA, 1);
    issue(4'hD, 16'd14, 16'd0, 1);

    // Abort a divide mid-iteration.
    issue(4'h3, 16'hFFFF, 16'h8001, 0);
    repeat (4) @(posedge CLK);
    #1 RST = 1'b1;
    busy_end = 0;
    @(posedge CLK);
    #1 RST = 1'b0;
    check_idle_zero("abort_reset");
    issue(4'h3, 16'hFFFF, 16'h8001, 1);
    issue(4'hF, 16'hFFFF, 16'h8001, 1);
    issue(4'hE, 16'h8001, 16'd0, 1);
    issue(4'hA, 16'h5A5A, 16'h5A5A, 1);
    issue(4'hC, 16'h0001, 16'hFFFF, 1);

    for (int i = 0; i < 150; i++) begin
      logic [3:0] op;
      logic [W-1:0] a, b;
      op = 4'($urandom_range(0, 15));
      a  = W'($urandom);
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = W'($urandom_range(1, 9));
        2: b = a;
        default: b = W'($urandom);
      endcase
      issue(op, a, b, 1);
      repeat ($urandom_range(0, 2)) @(posedge CLK);
      #1;
    end

    for (int n = 0; n < W + 10 && expq.size() != 0; n++) @(posedge CLK);
    repeat (2) @(posedge CLK);
    nchk++;
    if (expq.size() != 0) begin
      nerr++;
      $display("FAIL drain: %0d results outstanding, required 0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/alu_param_seq.md
Name: alu_param_seq

Overview:
Parametrised successor to the 16-bit registered ALU. Operand width is generic, and operations are accepted through a valid/ready handshake. MUL and the logic, compare and shift ops complete in one cycle. DIV and the new MOD op run on an iterative restoring divider with back-pressure. It sits between the operand register file and the result writeback stage.

Parameters:
WIDTH, 16, operand and result width in bits (min 4)

Ports:
CLK  in  1  clock, all state updates on rising edge
RST  in  1  synchronous active-high reset
IN_VALID  in  1  operation request
IN_READY  out  1  block can accept a request; equals (state==IDLE)
A  in  WIDTH  operand A
B  in  WIDTH  operand B
ALU_FUN  in  4  opcode
OUT_VALID  out  1  single-cycle pulse: result and flags updated this cycle
ALU_OUT  out  WIDTH  result, held until next result
Carry_Flag  out  1  carry/borrow/MUL overflow
Arith_Flag  out  1  last op was arithmetic (0000-0011, 1111)
Logic_Flag  out  1  last op was logic (0100-1001)
CMP_Flag  out  1  last op was compare (1010-1100)
Shift_Flag  out  1  last op was shift (1101-1110)
Div_Zero  out  1  last op was DIV/MOD with B==0

Behaviour:
- Reset: state=IDLE; ALU_OUT=0; all flags=0; OUT_VALID=0; IN_READY=1 in the cycle after reset. RST wins over every other event.
- Reset during DIV state aborts the operation. No OUT_VALID is produced.
- Accept: IN_VALID&&IN_READY sampled at edge k. A, B and ALU_FUN are captured. IN_VALID while IN_READY=0 is ignored, not queued.
- Opcodes:
  - 0000 ADD: A+B; Carry = bit WIDTH of the sum.
  - 0001 SUB: A-B, mod 2^WIDTH; Carry = borrow (A<B).
  - 0010 MUL: low WIDTH bits of A*B; Carry = 1 if the upper WIDTH bits are nonzero.
  - 0011 DIV: A/B, unsigned.
  - 1111 MOD: A%B, unsigned.
  - Logic: 0100 AND, 0101 OR, 0110 NAND, 0111 NOR, 1000 XOR, 1001 XNOR.
  - 1010 CMPEQ: 1 if A==B, else 0.
  - 1011 CMPG: 2 if A>B, else 0.
  - 1100 CMPL: 3 if A<B, else 0.
  - 1101 SHR: A>>1, zero fill.
  - 1110 SHL: A<<1, bit WIDTH-1 dropped. Carry = 0 for shifts.
- Carry_Flag is 0 for every op other than ADD, SUB and MUL.
- Exactly one category flag is 1 after each result. All category flags are updated with OUT_VALID.
- Single-cycle ops (all except DIV/MOD with B!=0):
  - Results and flags registered at edge k; OUT_VALID=1 for the cycle following edge k.
  - State stays IDLE, so back-to-back accepts are allowed every cycle.
- DIV/MOD with B==0: single-cycle path. ALU_OUT=0, Div_Zero=1, Arith_Flag=1, Carry=0.
- DIV/MOD with B!=0:
  - At edge k: state goes to DIV, iteration counter=0, and remainder register R=0, quotient register Q=A, divisor D=B are loaded.
  - Each edge k+1..k+WIDTH performs one restoring step: shift {R,Q} left 1; if R>=D then R-=D and set Q[0]=1; counter increments.
  - At edge k+WIDTH: ALU_OUT=Q (DIV) or R (MOD), Div_Zero=0, Arith_Flag=1, OUT_VALID pulse, state goes to IDLE.
  - IN_READY=0 during cycles k+1..k+WIDTH. A new accept is possible at edge k+WIDTH+1.
  - The remainder register is WIDTH+1 bits so it does not overflow when B has its MSB set.
- Div_Zero clears on any subsequent result.
- Outputs hold their last values while OUT_VALID=0.
- All arithmetic is unsigned. No X may propagate to the outputs after reset.

Test Plan:
- WIDTH=16, ADD A=0xFFFF B=0x0001 -> ALU_OUT=0x0000, Carry=1, Arith=1, OUT_VALID one cycle after accept.
- DIV A=100 B=7 -> IN_READY low 16 cycles; OUT_VALID 16 edges after accept; ALU_OUT=14. Repeat with MOD -> ALU_OUT=2, Div_Zero=0.
- DIV A=14 B=0 -> ALU_OUT=0, Div_Zero=1, OUT_VALID one cycle after accept, IN_READY never drops.
- MUL A=0x0100 B=0x0100 -> ALU_OUT=0x0000, Carry=1. Then MUL A=4 B=3 -> ALU_OUT=12, Carry=0.
- Back-to-back accepts SUB 15-4, XOR 0xAAAA^0x5555, CMPG 0xF,0xA, SHR 14 on consecutive cycles:
  - ALU_OUT values 11, 0xFFFF, 2, 7 appear on consecutive cycles with OUT_VALID held high.
  - The correct category flag is set on each cycle.
- DIV 0xFFFF/0x8001 with RST asserted at cycle 5 of the iteration:
  - No OUT_VALID; all outputs 0; IN_READY=1 after reset.
  - Then the same DIV unreset -> ALU_OUT=1, MOD -> 0x7FFE.
